// File: rtl/serial_word_adder_if.sv
// Operand/result handshake bundle for serial_word_adder.
// Defining SERIAL_WORD_ADDER_OVERFLOW_EN adds the signed-overflow flag.
interface serial_word_adder_if #(
   parameter int WORDS = 4
);
   localparam int W = 8 * WORDS;

   // valid/ready: a transfer happens on a rising clk edge where both are high;
   // the source holds its payload stable while valid is high and ready is low.
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         busy;
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
   logic         overflow;
`endif

   modport slave (
      input  in_valid, a, b, c_in, out_ready,
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
      output overflow,
`endif
      output in_ready, out_valid, sum, c_out, busy
   );

   modport master (
      output in_valid, a, b, c_in, out_ready,
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
      input  overflow,
`endif
      input  in_ready, out_valid, sum, c_out, busy
   );
endinterface

// File: rtl/serial_word_adder.sv
// Wide adder built from one 8-bit slice, one byte per clock with a registered carry.
// Optional SERIAL_WORD_ADDER_OVERFLOW_EN adds a registered signed-overflow flag.
module serial_word_adder #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_word_adder_if.slave    bus,
   output logic [1:0]            dbg_state
);
   localparam int W    = 8 * WORDS;
   localparam int IDXW = $clog2(WORDS + 1);
   localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            cy_q, cy_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            c_out_q, c_out_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic [8:0]      slice;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cy_d        = cy_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      c_out_d     = c_out_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      ovf_d       = ovf_q;
      slice       = {1'b0, a_q[8*idx_q +: 8]} + {1'b0, b_q[8*idx_q +: 8]} + {8'd0, cy_q};
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_d        = bus.a;
               b_d        = bus.b;
               cy_d       = bus.c_in;
               idx_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = ADD;
            end
         end
         ADD: begin
            sum_d[8*idx_q +: 8] = slice[7:0];
            cy_d                = slice[8];
            idx_d               = idx_q + 1'b1;
            if (idx_q == LAST) begin
               c_out_d     = slice[8];
               // Carry into the MSB is recovered from the MSB sum bit and operands.
               ovf_d       = a_q[W-1] ^ b_q[W-1] ^ slice[7] ^ slice[8];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cy_q        <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         c_out_q     <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cy_q        <= cy_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         c_out_q     <= c_out_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.c_out     = c_out_q;
   assign bus.busy      = busy_q;
   assign dbg_state     = state_q;

`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
   assign bus.overflow = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder: a WORDS=4 instance and a WORDS=1 instance.
module tb_serial_word_adder;
   logic clk;
   logic rst_n;
   logic [1:0] dbg_state4;
   logic [1:0] dbg_state1;
   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   serial_word_adder_if #(.WORDS(4)) bus  ();
   serial_word_adder_if #(.WORDS(1)) bus1 ();

   serial_word_adder #(.WORDS(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state4)
   );

   serial_word_adder #(.WORDS(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus1),
      .dbg_state (dbg_state1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at edge+1; returns at edge+1 once out_valid is seen (or budget expires).
   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, output int lat);
      bus.a        = av;
      bus.b        = bv;
      bus.c_in     = ci;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take_result();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int quiet;
      logic [31:0] ra, rb;
      logic rc;
      logic [32:0] e;

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.out_ready = 1'b0;
      #23 rst_n = 1'b1;
      @(posedge clk); #1;

      // reset state
      check("rst_sum", 64'(bus.sum), 64'h0);
      check("rst_c_out", 64'(bus.c_out), 64'h0);
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_in_ready", 64'(bus.in_ready), 64'h1);
      check("rst_state", 64'(dbg_state4), 64'h0);

      // wrap-around
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
      check("wrap_latency", 64'(lat), 64'd4);
      check("wrap_sum", 64'(bus.sum), 64'h0);
      check("wrap_c_out", 64'(bus.c_out), 64'h1);
      check("wrap_busy", 64'(bus.busy), 64'h1);
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
      check("wrap_overflow", 64'(bus.overflow), 64'h0);
`endif
      take_result();
      check("wrap_out_valid_drop", 64'(bus.out_valid), 64'h0);
      check("wrap_in_ready_back", 64'(bus.in_ready), 64'h1);

      // backpressure with ignored operands
      send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, lat);
      check("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555; bus.c_in = 1'b0; bus.in_valid = 1'b1;
         end
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         check("bp_sum", 64'(bus.sum), 64'h2143_6588);
         check("bp_c_out", 64'(bus.c_out), 64'h0);
         check("bp_out_valid", 64'(bus.out_valid), 64'h1);
         check("bp_in_ready", 64'(bus.in_ready), 64'h0);
      end
      take_result();
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid || bus.busy) quiet++;
      end
      check("bp_no_ghost_op", 64'(quiet), 64'd0);

`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
      check("ovf_pos_sum", 64'(bus.sum), 64'h8000_0000);
      check("ovf_pos_overflow", 64'(bus.overflow), 64'h1);
      check("ovf_pos_c_out", 64'(bus.c_out), 64'h0);
      take_result();
      send(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
      check("ovf_neg_sum", 64'(bus.sum), 64'h0);
      check("ovf_neg_overflow", 64'(bus.overflow), 64'h1);
      check("ovf_neg_c_out", 64'(bus.c_out), 64'h1);
      take_result();
`endif

      // random operands with random backpressure, scoreboard order check
      for (int n = 0; n < 100; n++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         exp_q.push_back({1'b0, ra} + {1'b0, rb} + {32'd0, rc});
         send(ra, rb, rc, lat);
         check("rand_latency", 64'(lat), 64'd4);
         for (int w = $urandom_range(0, 3); w > 0; w--) begin
            @(posedge clk); #1;
         end
         e = exp_q.pop_front();
         check("rand_result", 64'({bus.c_out, bus.sum}), 64'(e));
         take_result();
      end
      check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

      // asynchronous reset mid-ADD
      bus.a = 32'hDEAD_BEEF; bus.b = 32'h1357_9BDF; bus.c_in = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("mid_busy_before_rst", 64'(bus.busy), 64'h1);
      rst_n = 1'b0;
      #1;
      check("arst_sum", 64'(bus.sum), 64'h0);
      check("arst_c_out", 64'(bus.c_out), 64'h0);
      check("arst_out_valid", 64'(bus.out_valid), 64'h0);
      check("arst_busy", 64'(bus.busy), 64'h0);
      check("arst_state", 64'(dbg_state4), 64'h0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) quiet++;
      end
      check("post_rst_no_out_valid", 64'(quiet), 64'd0);
      send(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
      check("post_rst_latency", 64'(lat), 64'd4);
      check("post_rst_sum", 64'(bus.sum), 64'h8);
      check("post_rst_c_out", 64'(bus.c_out), 64'h0);
      take_result();

      // single-slice instance
      bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.c_in = 1'b1; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      check("w1_busy", 64'(bus1.busy), 64'h1);
      check("w1_out_valid_early", 64'(bus1.out_valid), 64'h0);
      @(posedge clk); #1;
      check("w1_out_valid", 64'(bus1.out_valid), 64'h1);
      check("w1_sum", 64'(bus1.sum), 64'hFF);
      check("w1_c_out", 64'(bus1.c_out), 64'h1);
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      check("w1_out_valid_drop", 64'(bus1.out_valid), 64'h0);
      check("w1_in_ready_back", 64'(bus1.in_ready), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
